// File: rtl/dmem_pkg.sv
// Shared types and constants for the dual-lane data-memory arbiter.
package dmem_pkg;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int XW = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SERVE1 = 1'b1
  } state_t;

  typedef struct packed {
    logic          isld;
    logic          isst;
    logic [XW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [RW-1:0] rd;
    logic          lane;
  } mem_op_t;

  function automatic logic op_active(input mem_op_t op);
    return op.isld | op.isst;
  endfunction

endpackage

// File: rtl/dmem_range_check.sv
// Splits a lane address into an in-range flag and the memory word address.
module dmem_range_check
  import dmem_pkg::*;
(
  input  logic [XW-1:0] addr,
  output logic          in_range,
  output logic [AW-1:0] word_addr
);

  assign in_range  = (addr[XW-1:AW] == {(XW-AW){1'b0}});
  assign word_addr = addr[AW-1:0];

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Serialises the two memory-stage lanes onto one memory port in program order,
// stalling the pipeline for one cycle when both lanes access memory together.
module dmem_lane_arbiter
  import dmem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l0_isld,
  input  logic             l0_isst,
  input  logic [XW-1:0]    l0_addr,
  input  logic [DW-1:0]    l0_wdata,
  input  logic [RW-1:0]    l0_rd,
  input  logic             l1_isld,
  input  logic             l1_isst,
  input  logic [XW-1:0]    l1_addr,
  input  logic [DW-1:0]    l1_wdata,
  input  logic [RW-1:0]    l1_rd,
  output logic             stall,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             rsp_valid,
  output logic             rsp_lane,
  output logic [DW-1:0]    rsp_data,
  output logic [RW-1:0]    rsp_rd,
  output logic             addr_err,
  output logic [CNT_W-1:0] conflict_cnt
);

  mem_op_t          op0_s, op1_s, lane1_src_s, buf_r;
  state_t           state_r;
  logic             in0_s, in1_s;
  logic [AW-1:0]    wa0_s, wa1_s;
  logic             slot_op_s, slot_isst_s, slot_in_s, slot_lane_s;
  logic [DW-1:0]    slot_wdata_s;
  logic [RW-1:0]    slot_rd_s;
  logic [AW-1:0]    slot_wa_s;
  logic             slot_act_s, slot_ok_s, slot_ld_s, dual_s;
  logic             rsp_zero_r;
  logic [CNT_W-1:0] cnt_r;

  assign op0_s = '{isld: l0_isld, isst: l0_isst, addr: l0_addr, wdata: l0_wdata, rd: l0_rd, lane: 1'b0};
  assign op1_s = '{isld: l1_isld, isst: l1_isst, addr: l1_addr, wdata: l1_wdata, rd: l1_rd, lane: 1'b1};

  // In SERVE1 the second lane slot comes from the buffer, not the frozen inputs.
  assign lane1_src_s = (state_r == SERVE1) ? buf_r : op1_s;

  dmem_range_check u_rc0 (.addr(op0_s.addr),       .in_range(in0_s), .word_addr(wa0_s));
  dmem_range_check u_rc1 (.addr(lane1_src_s.addr), .in_range(in1_s), .word_addr(wa1_s));

  // Pick the op that owns the memory port this cycle.
  always_comb begin
    slot_op_s    = 1'b0;
    slot_isst_s  = 1'b0;
    slot_in_s    = 1'b0;
    slot_lane_s  = 1'b0;
    slot_wdata_s = {DW{1'b0}};
    slot_rd_s    = {RW{1'b0}};
    slot_wa_s    = {AW{1'b0}};
    case (state_r)
      IDLE: begin
        if (op_active(op0_s)) begin
          slot_op_s    = 1'b1;
          slot_isst_s  = op0_s.isst;
          slot_in_s    = in0_s;
          slot_lane_s  = op0_s.lane;
          slot_wdata_s = op0_s.wdata;
          slot_rd_s    = op0_s.rd;
          slot_wa_s    = wa0_s;
        end else begin
          slot_op_s    = op_active(lane1_src_s);
          slot_isst_s  = lane1_src_s.isst;
          slot_in_s    = in1_s;
          slot_lane_s  = lane1_src_s.lane;
          slot_wdata_s = lane1_src_s.wdata;
          slot_rd_s    = lane1_src_s.rd;
          slot_wa_s    = wa1_s;
        end
      end
      SERVE1: begin
        slot_op_s    = op_active(lane1_src_s);
        slot_isst_s  = lane1_src_s.isst;
        slot_in_s    = in1_s;
        slot_lane_s  = lane1_src_s.lane;
        slot_wdata_s = lane1_src_s.wdata;
        slot_rd_s    = lane1_src_s.rd;
        slot_wa_s    = wa1_s;
      end
      default: begin
        slot_op_s = 1'b0;
      end
    endcase
  end

  // Reset gates the port so a buffered op cannot write while being discarded.
  assign slot_act_s = slot_op_s & ~reset;
  assign slot_ok_s  = slot_act_s & slot_in_s;
  assign slot_ld_s  = slot_act_s & ~slot_isst_s;
  assign dual_s     = (state_r == IDLE) & op_active(op0_s) & op_active(op1_s) & ~reset;

  assign stall        = dual_s;
  assign mem_en       = slot_ok_s;
  assign mem_we       = slot_ok_s & slot_isst_s;
  assign mem_addr     = slot_ok_s ? slot_wa_s : {AW{1'b0}};
  assign mem_wdata    = (slot_ok_s & slot_isst_s) ? slot_wdata_s : {DW{1'b0}};
  assign rsp_data     = (rsp_valid & ~rsp_zero_r) ? mem_rdata : {DW{1'b0}};
  assign conflict_cnt = cnt_r;

  // State, conflict buffer, response tags, error pulse and conflict counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      buf_r      <= '0;
      rsp_valid  <= 1'b0;
      rsp_lane   <= 1'b0;
      rsp_rd     <= {RW{1'b0}};
      rsp_zero_r <= 1'b0;
      addr_err   <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (dual_s) begin
            state_r <= SERVE1;
            buf_r   <= op1_s;
            if (cnt_r != {CNT_W{1'b1}}) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SERVE1: begin
          state_r <= IDLE;
          buf_r   <= '0;
        end
        default: begin
          state_r <= IDLE;
          buf_r   <= '0;
        end
      endcase
      rsp_valid <= slot_ld_s;
      addr_err  <= slot_act_s & ~slot_in_s;
      if (slot_ld_s) begin
        rsp_lane   <= slot_lane_s;
        rsp_rd     <= slot_rd_s;
        rsp_zero_r <= ~slot_in_s;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Randomised scoreboard bench for dmem_lane_arbiter against a program-order memory model.
module tb_dmem_lane_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int RW    = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             l0_isld, l0_isst, l1_isld, l1_isst;
  logic [15:0]      l0_addr, l1_addr;
  logic [DW-1:0]    l0_wdata, l1_wdata;
  logic [RW-1:0]    l0_rd, l1_rd;
  logic             stall, mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;
  logic             rsp_valid, rsp_lane, addr_err;
  logic [DW-1:0]    rsp_data;
  logic [RW-1:0]    rsp_rd;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  dmem_lane_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .l0_isld(l0_isld), .l0_isst(l0_isst), .l0_addr(l0_addr), .l0_wdata(l0_wdata), .l0_rd(l0_rd),
    .l1_isld(l1_isld), .l1_isst(l1_isst), .l1_addr(l1_addr), .l1_wdata(l1_wdata), .l1_rd(l1_rd),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .addr_err(addr_err), .conflict_cnt(conflict_cnt)
  );

  // Single-port memory with a bench-side preload port.
  logic [DW-1:0] mem [32];
  logic          pre_we = 1'b0;
  logic [4:0]    pre_addr = 5'd0;
  logic [DW-1:0] pre_data = 16'd0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic          lane;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [32];
  int            n_cmp = 0, n_bad = 0;
  int            exp_err = 0, err_seen = 0, duals = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every returned load is matched against the oldest expected response.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got lane %0d rd %0d data %0h, required no response", rsp_lane, rsp_rd, rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_lane", rsp_lane, e.lane);
        chk("rsp_rd",   rsp_rd,   e.rd);
        chk("rsp_data", rsp_data, e.data);
      end
    end
    if (addr_err) err_seen++;
  end

  // Program-order reference: kind 1=load, 2/3=store, 0=none.
  task automatic model_op(input logic lane, input logic [1:0] k, input logic [15:0] a,
                          input logic [DW-1:0] d, input logic [RW-1:0] r);
    rsp_t e;
    if (k == 2'd0) return;
    e.lane = lane; e.rd = r;
    if (a > 16'd31) begin
      exp_err++;
      if (k == 2'd1) begin e.data = 16'd0; exp_q.push_back(e); end
    end else if (k[1]) ref_mem[a[4:0]] = d;
    else begin e.data = ref_mem[a[4:0]]; exp_q.push_back(e); end
  endtask

  task automatic chk_slot(input logic [1:0] k, input logic [15:0] a, input logic [DW-1:0] d);
    logic en;
    en = (a <= 16'd31);
    chk("mem_en",   mem_en,   en);
    chk("mem_we",   mem_we,   en & k[1]);
    chk("mem_addr", mem_addr, en ? a[4:0] : 5'd0);
    if (k[1] || !en) chk("mem_wdata", mem_wdata, (en & k[1]) ? d : 16'd0);
  endtask

  task automatic drive(input logic [1:0] k0, input logic [15:0] a0, input logic [DW-1:0] d0, input logic [RW-1:0] r0,
                       input logic [1:0] k1, input logic [15:0] a1, input logic [DW-1:0] d1, input logic [RW-1:0] r1);
    l0_isld = k0[0]; l0_isst = k0[1]; l0_addr = a0; l0_wdata = d0; l0_rd = r0;
    l1_isld = k1[0]; l1_isst = k1[1]; l1_addr = a1; l1_wdata = d1; l1_rd = r1;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive(2'd0, 16'd0, 16'd0, 3'd0, 2'd0, 16'd0, 16'd0, 3'd0);
    @(negedge clk);
    chk("idle_stall", stall, 1'b0);
    chk("idle_mem_en", mem_en, 1'b0);
  endtask

  task automatic issue_pair(input logic [1:0] k0, input logic [15:0] a0, input logic [DW-1:0] d0, input logic [RW-1:0] r0,
                            input logic [1:0] k1, input logic [15:0] a1, input logic [DW-1:0] d1, input logic [RW-1:0] r1);
    logic v0, v1;
    v0 = (k0 != 2'd0); v1 = (k1 != 2'd0);
    @(posedge clk); #1;
    drive(k0, a0, d0, r0, k1, a1, d1, r1);
    @(negedge clk);
    chk("stall", stall, v0 & v1);
    if (v0) chk_slot(k0, a0, d0);
    else if (v1) chk_slot(k1, a1, d1);
    else chk("none_mem_en", mem_en, 1'b0);
    model_op(1'b0, k0, a0, d0, r0);
    model_op(1'b1, k1, a1, d1, r1);
    if (v0 && v1) begin
      duals++;
      @(posedge clk); #1;
      // Lane inputs are don't-care while the buffered op is served.
      drive(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 3'($urandom),
            2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 3'($urandom));
      @(negedge clk);
      chk("stall_serve1", stall, 1'b0);
      chk_slot(k1, a1, d1);
      chk("conflict_cnt", conflict_cnt, (duals > 15) ? 15 : duals);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return {11'($urandom_range(1, 2047)), 5'($urandom_range(0, 31))};
    return 16'($urandom_range(0, 31));
  endfunction

  task automatic random_pair(input bit force_dual, input bit force_single);
    logic [1:0] k0, k1;
    k0 = 2'($urandom_range(0, 3));
    k1 = 2'($urandom_range(0, 3));
    if (force_dual) begin
      if (k0 == 2'd0) k0 = 2'd1;
      if (k1 == 2'd0) k1 = 2'd2;
    end
    if (force_single) begin
      if ($urandom_range(0, 1) == 0) begin k0 = 2'd0; k1 = 2'($urandom_range(1, 3)); end
      else begin k1 = 2'd0; k0 = 2'($urandom_range(1, 3)); end
    end
    issue_pair(k0, rand_addr(), 16'($urandom), 3'($urandom), k1, rand_addr(), 16'($urandom), 3'($urandom));
  endtask

  task automatic reset_mid(input logic [1:0] k1);
    repeat (3) idle_cycle();
    @(posedge clk); #1;
    drive(2'd2, 16'd10, 16'($urandom), 3'd1, k1, 16'd11, 16'($urandom), 3'd6);
    @(negedge clk);
    chk("rst_dual_stall", stall, 1'b1);
    model_op(1'b0, 2'd2, 16'd10, l0_wdata, 3'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_serve1_mem_en", mem_en, 1'b0);
    chk("rst_serve1_stall", stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    duals = 0;
    drive(2'd0, 16'd0, 16'd0, 3'd0, 2'd0, 16'd0, 16'd0, 3'd0);
    @(negedge clk);
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);
    chk("post_rst_rsp_lane", rsp_lane, 1'b0);
    chk("post_rst_rsp_rd", rsp_rd, 3'd0);
    chk("post_rst_rsp_data", rsp_data, 16'd0);
    chk("post_rst_addr_err", addr_err, 1'b0);
    chk("post_rst_cnt", conflict_cnt, 4'd0);
    chk("post_rst_mem_en", mem_en, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_words;
    reset = 1'b1;
    drive(2'd0, 16'd0, 16'd0, 3'd0, 2'd0, 16'd0, 16'd0, 3'd0);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = 5'(i);
      pre_data = (i == 3) ? 16'hBEEF : 16'($urandom);
      ref_mem[i] = pre_data;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_lane", rsp_lane, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'd0);
    chk("rst_rsp_rd", rsp_rd, 3'd0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_cnt", conflict_cnt, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single load of a preloaded word.
    issue_pair(2'd1, 16'd3, 16'd0, 3'd5, 2'd0, 16'd0, 16'd0, 3'd0);
    idle_cycle();
    // Store then load of the same word in one pair.
    issue_pair(2'd2, 16'd7, 16'h1234, 3'd0, 2'd1, 16'd7, 16'd0, 3'd2);
    idle_cycle();
    // Out-of-range load and store.
    issue_pair(2'd0, 16'd0, 16'd0, 3'd0, 2'd1, 16'h0040, 16'd0, 3'd4);
    idle_cycle();
    chk("oor_load_addr_err", addr_err, 1'b1);
    issue_pair(2'd2, 16'h0020, 16'hAAAA, 3'd0, 2'd0, 16'd0, 16'd0, 3'd0);
    idle_cycle();
    chk("oor_store_addr_err", addr_err, 1'b1);

    reset_mid(2'd2);
    reset_mid(2'd1);

    for (int i = 0; i < 10; i++) begin
      random_pair(1'b0, 1'b1);
      random_pair(1'b1, 1'b0);
    end
    for (int i = 0; i < 300; i++) random_pair(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) random_pair(1'b1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle_cycle();
    idle_cycle();
    chk("drain_queue", exp_q.size(), 0);
    chk("addr_err_count", err_seen, exp_err);
    bad_words = 0;
    for (int i = 0; i < 32; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        bad_words++;
        $display("FAIL mem_word[%0d]: got %0h, required %0h", i, mem[i], ref_mem[i]);
      end
    end
    n_cmp++;
    if (bad_words != 0) n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lane_arbiter.md
Name: dmem_lane_arbiter

Overview:
- Shares the single-port 32x16 data memory between the two memory-stage lanes of the dual-issue pipeline.
- Lane 0 is always the older instruction of an issue pair. When both lanes carry a load or store in the same cycle, the block serializes them in program order and asserts a one-cycle pipeline stall.
- Drives the memory port and returns load data tagged with lane and destination register. Range-checks addresses and counts dual-access conflicts.

Parameters:
- AW, 5, memory word-address width (32 words)
- DW, 16, data width
- RW, 3, destination register field width (instr[7:5])
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- l0_isld  in  1  lane 0 load
- l0_isst  in  1  lane 0 store
- l0_addr  in  16  lane 0 ALU result (word address)
- l0_wdata  in  DW  lane 0 store data (op2)
- l0_rd  in  RW  lane 0 destination register
- l1_isld, l1_isst, l1_addr, l1_wdata, l1_rd  in  same  lane 1 equivalents
- stall  out  1  freeze the upstream pipeline; the same issue pair is re-presented next cycle
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe (valid with mem_en)
- mem_addr  out  AW  memory word address
- mem_wdata  out  DW  store data
- mem_rdata  in  DW  read data, valid one cycle after a read access
- rsp_valid  out  1  load data returned
- rsp_lane  out  1  lane of the returned load
- rsp_data  out  DW  load data (0 on range error)
- rsp_rd  out  RW  destination register of the returned load
- addr_err  out  1  one-cycle pulse: an access was dropped because addr[15:AW] != 0
- conflict_cnt  out  CNT_W  number of dual-access stalls, saturating

Behaviour:
- Lane op = isld|isst. isld and isst both high on one lane is treated as a store.
- States: IDLE, SERVE1.
- IDLE, no lane op: mem_en=0, stall=0.
- IDLE, exactly one lane op: that op drives the memory port combinationally this cycle, stall=0, stay in IDLE.
- IDLE, both lane ops: lane 0 drives the port this cycle. Lane 1's isld, isst, addr, wdata and rd are latched into the buffer. stall=1 combinationally in the same cycle. Go to SERVE1.
- SERVE1: the buffered lane 1 op drives the port, stall=0, go to IDLE. All lane inputs are ignored this cycle (upstream is re-presenting the frozen pair).
- Ordering: lane 0 always writes before lane 1 reads. A lane 0 store followed by a lane 1 load to the same address returns the new data; no forwarding logic is needed.
- Range check: if addr[15:AW] != 0, then mem_en=0 for that slot and addr_err pulses in the cycle after the slot. A load still produces a response with rsp_data=0. A store is dropped.
- Load response: rsp_valid is registered, one cycle after the read slot. rsp_data=mem_rdata, rsp_lane and rsp_rd come from the served op. Stores produce no response.
- conflict_cnt increments on each IDLE->SERVE1 transition and saturates at all-ones.
- Reset:
  - state=IDLE, buffer cleared; stall=0, mem_en=0, mem_we=0.
  - rsp_valid=0, rsp_lane=0, rsp_data=0, rsp_rd=0.
  - addr_err=0, conflict_cnt=0.
  - Reset during SERVE1 discards the buffered op: no memory write, no response.
  - A response pending from the cycle reset is sampled is suppressed.
- mem_addr and mem_wdata are 0 whenever mem_en=0.

Decomposition:
- Shared package dmem_pkg: AW, DW, RW constants, the state enum {IDLE, SERVE1}, and a mem_op struct {isld, isst, addr, wdata, rd, lane}.
- One natural sub-module, dmem_range_check: combinational address-to-{in_range, word_addr}. It is instanced per lane and is reused by later cache work.

Test Plan:
- Single load: lane 0 isld, addr=3, memory[3]=0xBEEF, rd=5 -> mem_en=1, we=0, addr=3 in cycle 0; rsp_valid=1, data=0xBEEF, lane=0, rd=5 in cycle 1; stall never asserted.
- Dual conflict: lane 0 store addr=7 data=0x1234 with lane 1 load addr=7 rd=2 -> stall=1 in cycle 0 with a write to 7; read of 7 in cycle 1; rsp data=0x1234, lane=1, rd=2 in cycle 2; conflict_cnt=1.
- Out of range: lane 1 load addr=0x0040 rd=4 -> mem_en=0; next cycle addr_err=1, rsp_valid=1, data=0, lane=1. Store to 0x0020 -> no write, addr_err=1, no response.
- Reset mid-operation: dual store/store with reset asserted in the SERVE1 cycle -> only the lane 0 write occurs; all outputs 0 in the cycle after reset; state IDLE.
- Back-to-back: alternating single ops and dual pairs for 20 cycles -> every load response in program order; stall only in dual cycles; memory contents match the reference model.
- Saturation: preload conflict_cnt near all-ones (CNT_W=4 build), then 20 dual pairs -> counter holds at 0xF.
